// File: rtl/cache_refill_ctrl_pkg.sv
// Shared sizing defaults, FSM encoding and field-width helper for the cache miss refill controller.
package cache_refill_ctrl_pkg;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_WORD_WIDTH     = 32;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_INDEX_BITS     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FILL  = 2'd2
    } refill_state_e;

    // Tag is whatever is left above index, word offset and the two byte-offset bits.
    function automatic int tag_bits(input int addr_width, input int index_bits, input int words_per_line);
        return addr_width - index_bits - $clog2(words_per_line) - 2;
    endfunction
endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Miss/fill handshake with the cache plus the word-wide read port to main memory.
interface cache_refill_if
    import cache_refill_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int INDEX_BITS     = DEF_INDEX_BITS
);
    localparam int TAG_BITS = tag_bits(ADDR_WIDTH, INDEX_BITS, WORDS_PER_LINE);

    logic                                 miss_req;
    logic [ADDR_WIDTH-1:0]                miss_addr;
    logic                                 busywait;
    logic                                 mem_read;
    logic [ADDR_WIDTH-1:0]                mem_address;
    logic [WORD_WIDTH-1:0]                mem_readdata;
    logic                                 mem_busywait;
    logic                                 fill_we;
    logic [INDEX_BITS-1:0]                fill_index;
    logic [TAG_BITS-1:0]                  fill_tag;
    logic [WORD_WIDTH*WORDS_PER_LINE-1:0] fill_line;
    logic                                 refill_err;

    modport master (
        input  miss_req, miss_addr, mem_readdata, mem_busywait,
        output busywait, mem_read, mem_address, fill_we, fill_index, fill_tag, fill_line, refill_err
    );

    modport slave (
        output miss_req, miss_addr, mem_readdata, mem_busywait,
        input  busywait, mem_read, mem_address, fill_we, fill_index, fill_tag, fill_line, refill_err
    );
endinterface

// File: rtl/cache_refill_ctrl_line_buffer.sv
// Line assembly register: one word written per capture, flat line out with word 0 in the LSBs.
module cache_line_buffer #(
    parameter int  WORD_WIDTH     = 32,
    parameter int  WORDS_PER_LINE = 4,
    localparam int WOFF_BITS      = $clog2(WORDS_PER_LINE)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 srst,
    input  logic                                 we,
    input  logic [WOFF_BITS-1:0]                 sel,
    input  logic [WORD_WIDTH-1:0]                wdata,
    output logic [WORD_WIDTH*WORDS_PER_LINE-1:0] line
);
    logic [WORD_WIDTH*WORDS_PER_LINE-1:0] line_r;

    // Line storage: cleared on reset or discard, otherwise the selected word is overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_r <= '0;
        end else if (srst) begin
            line_r <= '0;
        end else if (we) begin
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                if (sel == WOFF_BITS'(i)) begin
                    line_r[i*WORD_WIDTH +: WORD_WIDTH] <= wdata;
                end
            end
        end
    end

    assign line = line_r;
endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill controller: fetches a line word by word from memory, then writes it to the
// cache in a single fill cycle, aborting with refill_err if memory stays busy too long.
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int INDEX_BITS     = DEF_INDEX_BITS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic           clk,
    input logic           reset,
    cache_refill_if.master bus
);
    localparam int WOFF_BITS = $clog2(WORDS_PER_LINE);
    localparam int TAG_BITS  = tag_bits(ADDR_WIDTH, INDEX_BITS, WORDS_PER_LINE);
    localparam int TO_BITS   = $clog2(TIMEOUT_CYCLES);

    localparam logic [TO_BITS-1:0]    TO_LAST   = TO_BITS'(TIMEOUT_CYCLES - 2);
    localparam logic [WOFF_BITS-1:0]  WORD_LAST = WOFF_BITS'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << (WOFF_BITS + 2)) - ADDR_WIDTH'(1));

    refill_state_e                        state_r, state_s;
    logic [ADDR_WIDTH-1:0]                base_addr_r, base_addr_s;
    logic [ADDR_WIDTH-1:0]                mem_address_r, mem_address_s;
    logic [WOFF_BITS-1:0]                 word_cnt_r, word_cnt_s;
    logic [TO_BITS-1:0]                   timeout_cnt_r, timeout_cnt_s;
    logic                                 mem_read_r, mem_read_s;
    logic                                 fill_we_r, fill_we_s;
    logic                                 refill_err_r, refill_err_s;
    logic [INDEX_BITS-1:0]                fill_index_r, fill_index_s;
    logic [TAG_BITS-1:0]                  fill_tag_r, fill_tag_s;
    logic                                 busywait_s;
    logic                                 capture_s;
    logic                                 buf_clr_s;
    logic [WORD_WIDTH*WORDS_PER_LINE-1:0] line_s;

    // Next-state, counter and output decode; busywait is the only combinational output.
    always_comb begin
        state_s       = state_r;
        base_addr_s   = base_addr_r;
        word_cnt_s    = word_cnt_r;
        timeout_cnt_s = timeout_cnt_r;
        mem_read_s    = 1'b0;
        fill_we_s     = 1'b0;
        refill_err_s  = 1'b0;
        fill_index_s  = fill_index_r;
        fill_tag_s    = fill_tag_r;
        busywait_s    = 1'b1;
        capture_s     = 1'b0;
        buf_clr_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // Stall in the miss cycle itself so the CPU never sees a stale hit.
                busywait_s = bus.miss_req;
                if (bus.miss_req) begin
                    state_s       = ST_FETCH;
                    base_addr_s   = bus.miss_addr & LINE_MASK;
                    word_cnt_s    = '0;
                    timeout_cnt_s = '0;
                    mem_read_s    = 1'b1;
                    buf_clr_s     = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                mem_read_s = 1'b1;
                if (!bus.mem_busywait) begin
                    capture_s     = 1'b1;
                    word_cnt_s    = word_cnt_r + 1'b1;
                    timeout_cnt_s = '0;
                    if (word_cnt_r == WORD_LAST) begin
                        state_s      = ST_FILL;
                        mem_read_s   = 1'b0;
                        fill_we_s    = 1'b1;
                        fill_index_s = base_addr_r[WOFF_BITS+2 +: INDEX_BITS];
                        fill_tag_s   = base_addr_r[ADDR_WIDTH-1 -: TAG_BITS];
                    end else begin
                        state_s = ST_FETCH;
                    end
                end else if (timeout_cnt_r == TO_LAST) begin
                    state_s       = ST_IDLE;
                    timeout_cnt_s = timeout_cnt_r + 1'b1;
                    mem_read_s    = 1'b0;
                    refill_err_s  = 1'b1;
                    buf_clr_s     = 1'b1;
                end else begin
                    timeout_cnt_s = timeout_cnt_r + 1'b1;
                end
            end
            ST_FILL: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Address always tracks the word about to be fetched, so it advances one cycle after capture.
        mem_address_s = base_addr_s + (ADDR_WIDTH'(word_cnt_s) << 2'd2);
    end

    // State, counters and registered outputs; reset drops every request immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            base_addr_r   <= '0;
            mem_address_r <= '0;
            word_cnt_r    <= '0;
            timeout_cnt_r <= '0;
            mem_read_r    <= 1'b0;
            fill_we_r     <= 1'b0;
            refill_err_r  <= 1'b0;
            fill_index_r  <= '0;
            fill_tag_r    <= '0;
        end else begin
            state_r       <= state_s;
            base_addr_r   <= base_addr_s;
            mem_address_r <= mem_address_s;
            word_cnt_r    <= word_cnt_s;
            timeout_cnt_r <= timeout_cnt_s;
            mem_read_r    <= mem_read_s;
            fill_we_r     <= fill_we_s;
            refill_err_r  <= refill_err_s;
            fill_index_r  <= fill_index_s;
            fill_tag_r    <= fill_tag_s;
        end
    end

    cache_line_buffer #(
        .WORD_WIDTH     (WORD_WIDTH),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_line_buf (
        .clk   (clk),
        .rst_n (reset),
        .srst  (buf_clr_s),
        .we    (capture_s),
        .sel   (word_cnt_r),
        .wdata (bus.mem_readdata),
        .line  (line_s)
    );

    assign bus.busywait    = busywait_s;
    assign bus.mem_read    = mem_read_r;
    assign bus.mem_address = mem_address_r;
    assign bus.fill_we     = fill_we_r;
    assign bus.fill_index  = fill_index_r;
    assign bus.fill_tag    = fill_tag_r;
    assign bus.fill_line   = line_s;
    assign bus.refill_err  = refill_err_r;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: cycle table for a zero-wait refill, then hand-written
// sequences for wait states, timeout, input changes mid-refill, back-to-back misses, reset and a narrow line.
module tb_cache_refill_ctrl;
    logic clk;
    logic reset;
    int   pass_n   = 0;
    int   total_n  = 0;
    int   wait_n   = 0;
    logic stuck    = 1'b0;
    int   wait_cnt = 0;

    cache_refill_if #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .WORDS_PER_LINE(4), .INDEX_BITS(4)) ifc ();
    cache_refill_if #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .WORDS_PER_LINE(2), .INDEX_BITS(6)) ifc2 ();

    cache_refill_ctrl #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .WORDS_PER_LINE(4), .INDEX_BITS(4),
                        .TIMEOUT_CYCLES(64)) dut (.clk(clk), .reset(reset), .bus(ifc));
    cache_refill_ctrl #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .WORDS_PER_LINE(2), .INDEX_BITS(6),
                        .TIMEOUT_CYCLES(64)) dut2 (.clk(clk), .reset(reset), .bus(ifc2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: wait_n busy cycles before each word (or forever when stuck), data = address.
    assign ifc.mem_busywait = stuck | (ifc.mem_read & (wait_cnt < wait_n));
    assign ifc.mem_readdata = ifc.mem_busywait ? 32'hDEAD_BEEF : ifc.mem_address;
    always @(posedge clk) wait_cnt <= ifc.mem_busywait ? wait_cnt + 1 : 0;

    assign ifc2.mem_busywait = 1'b0;
    assign ifc2.mem_readdata = ifc2.mem_address;

    typedef struct {
        logic        miss_req;
        logic [31:0] miss_addr;
        logic        busy;
        logic        rd;
        logic        we;
        logic        err;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One refill on ifc starting from IDLE; observes `cycles` cycles after the miss cycle.
    task automatic run_refill(input logic [31:0] addr, input int cycles, input bit wiggle,
                              output int fetch_n, output int fill_n, output int err_n,
                              output int idle_n, output logic [3:0] idx,
                              output logic [23:0] tag, output logic [127:0] line);
        fetch_n = 0; fill_n = 0; err_n = 0; idle_n = 0;
        idx = '0; tag = '0; line = '0;
        ifc.miss_req  = 1'b1;
        ifc.miss_addr = addr;
        @(posedge clk); #1;
        ifc.miss_req = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            if (wiggle && c < 3) begin
                ifc.miss_req  = ~c[0];
                ifc.miss_addr = 32'hFFFF_FF00 + 32'(c);
            end else begin
                ifc.miss_req = 1'b0;
            end
            @(negedge clk);
            if (ifc.mem_read) fetch_n++;
            if (ifc.refill_err) err_n++;
            if (!ifc.busywait) idle_n++;
            if (ifc.fill_we) begin
                fill_n++;
                idx  = ifc.fill_index;
                tag  = ifc.fill_tag;
                line = ifc.fill_line;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int           fetch_n, fill_n, err_n, idle_n, busy_n;
        logic [3:0]   idx;
        logic [23:0]  tag;
        logic [127:0] line;
        logic         found;
        logic [5:0]   idx2;
        logic [22:0]  tag2;
        logic [63:0]  line2;

        vecs[0] = '{1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1230};
        vecs[2] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1234};
        vecs[3] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1238};
        vecs[4] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_123C};
        vecs[5] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
        vecs[6] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};

        reset          = 1'b0;
        ifc.miss_req   = 1'b0;
        ifc.miss_addr  = 32'h0;
        ifc2.miss_req  = 1'b0;
        ifc2.miss_addr = 32'h0;
        #12;
        check("rst_busywait", 128'(ifc.busywait), 128'(0));
        check("rst_mem_read", 128'(ifc.mem_read), 128'(0));
        check("rst_mem_address", 128'(ifc.mem_address), 128'(0));
        check("rst_fill_we", 128'(ifc.fill_we), 128'(0));
        check("rst_refill_err", 128'(ifc.refill_err), 128'(0));
        check("rst_fill_index", 128'(ifc.fill_index), 128'(0));
        check("rst_fill_tag", 128'(ifc.fill_tag), 128'(0));
        check("rst_fill_line", ifc.fill_line, 128'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Zero-wait refill of 0x1234, cycle by cycle.
        for (int i = 0; i < 7; i++) begin
            ifc.miss_req  = vecs[i].miss_req;
            ifc.miss_addr = vecs[i].miss_addr;
            @(negedge clk);
            check($sformatf("t1_busywait[%0d]", i), 128'(ifc.busywait), 128'(vecs[i].busy));
            check($sformatf("t1_mem_read[%0d]", i), 128'(ifc.mem_read), 128'(vecs[i].rd));
            check($sformatf("t1_fill_we[%0d]", i), 128'(ifc.fill_we), 128'(vecs[i].we));
            check($sformatf("t1_refill_err[%0d]", i), 128'(ifc.refill_err), 128'(vecs[i].err));
            if (vecs[i].rd)
                check($sformatf("t1_mem_address[%0d]", i), 128'(ifc.mem_address), 128'(vecs[i].addr));
            if (vecs[i].we) begin
                check("t1_fill_index", 128'(ifc.fill_index), 128'(4'h3));
                check("t1_fill_tag", 128'(ifc.fill_tag), 128'(24'h000012));
                check("t1_fill_line", ifc.fill_line,
                      {32'h0000_123C, 32'h0000_1238, 32'h0000_1234, 32'h0000_1230});
            end
            @(posedge clk); #1;
        end

        // Three busy cycles before every word.
        wait_n = 3;
        run_refill(32'h0000_2008, 24, 1'b0, fetch_n, fill_n, err_n, idle_n, idx, tag, line);
        check("t2_fetch_cycles", 128'(fetch_n), 128'(16));
        check("t2_fill_count", 128'(fill_n), 128'(1));
        check("t2_refill_err", 128'(err_n), 128'(0));
        check("t2_fill_index", 128'(idx), 128'(4'h0));
        check("t2_fill_tag", 128'(tag), 128'(24'h000020));
        check("t2_fill_line", line, {32'h0000_200C, 32'h0000_2008, 32'h0000_2004, 32'h0000_2000});
        wait_n = 0;

        // Memory never answers: abort after 63 busy cycles.
        stuck = 1'b1;
        run_refill(32'h0000_3000, 70, 1'b0, fetch_n, fill_n, err_n, idle_n, idx, tag, line);
        stuck = 1'b0;
        check("t3_fetch_cycles", 128'(fetch_n), 128'(63));
        check("t3_err_pulses", 128'(err_n), 128'(1));
        check("t3_fill_count", 128'(fill_n), 128'(0));
        check("t3_busy_low_cycles", 128'(idle_n), 128'(7));

        // miss_req/miss_addr change during FETCH and must be ignored.
        run_refill(32'h0000_0A58, 8, 1'b1, fetch_n, fill_n, err_n, idle_n, idx, tag, line);
        check("t5_fetch_cycles", 128'(fetch_n), 128'(4));
        check("t5_fill_count", 128'(fill_n), 128'(1));
        check("t5_fill_index", 128'(idx), 128'(4'h5));
        check("t5_fill_tag", 128'(tag), 128'(24'h00000A));
        check("t5_fill_line", line, {32'h0000_0A5C, 32'h0000_0A58, 32'h0000_0A54, 32'h0000_0A50});

        // miss_req held through FILL: second refill follows with no busywait gap.
        ifc.miss_req  = 1'b1;
        ifc.miss_addr = 32'h0000_0080;
        busy_n = 0; fill_n = 0; fetch_n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ifc.busywait) busy_n++;
            if (ifc.fill_we) fill_n++;
            if (ifc.mem_read) fetch_n++;
            @(posedge clk); #1;
        end
        ifc.miss_req = 1'b0;
        check("t5b_busy_cycles", 128'(busy_n), 128'(12));
        check("t5b_fill_count", 128'(fill_n), 128'(2));
        check("t5b_fetch_cycles", 128'(fetch_n), 128'(8));
        @(posedge clk); #1;

        // Reset in the middle of FETCH word 2, checked before any clock edge.
        ifc.miss_req  = 1'b1;
        ifc.miss_addr = 32'h0000_5000;
        @(posedge clk); #1;
        ifc.miss_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (ifc.mem_read && ifc.mem_address == 32'h0000_5008) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("t4_word2_reached", 128'(found), 128'(1));
        reset = 1'b0;
        #1;
        check("t4_busywait", 128'(ifc.busywait), 128'(0));
        check("t4_mem_read", 128'(ifc.mem_read), 128'(0));
        check("t4_mem_address", 128'(ifc.mem_address), 128'(0));
        check("t4_fill_we", 128'(ifc.fill_we), 128'(0));
        check("t4_refill_err", 128'(ifc.refill_err), 128'(0));
        check("t4_fill_line", ifc.fill_line, 128'(0));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        run_refill(32'h0000_0040, 8, 1'b0, fetch_n, fill_n, err_n, idle_n, idx, tag, line);
        check("t4_refill_fetch", 128'(fetch_n), 128'(4));
        check("t4_refill_fill", 128'(fill_n), 128'(1));
        check("t4_refill_err", 128'(err_n), 128'(0));
        check("t4_fill_index", 128'(idx), 128'(4'h4));
        check("t4_fill_tag", 128'(tag), 128'(24'h000000));
        check("t4_fill_line", line, {32'h0000_004C, 32'h0000_0048, 32'h0000_0044, 32'h0000_0040});

        // Two-word line, six index bits: index = addr[8:3], tag = addr[31:9].
        ifc2.miss_req  = 1'b1;
        ifc2.miss_addr = 32'h0000_1234;
        @(posedge clk); #1;
        ifc2.miss_req = 1'b0;
        fetch_n = 0; fill_n = 0;
        idx2 = '0; tag2 = '0; line2 = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ifc2.mem_read) fetch_n++;
            if (ifc2.fill_we) begin
                fill_n++;
                idx2  = ifc2.fill_index;
                tag2  = ifc2.fill_tag;
                line2 = ifc2.fill_line;
            end
            @(posedge clk); #1;
        end
        check("t6_fetch_cycles", 128'(fetch_n), 128'(2));
        check("t6_fill_count", 128'(fill_n), 128'(1));
        check("t6_fill_index", 128'(idx2), 128'(6'h06));
        check("t6_fill_tag", 128'(tag2), 128'(23'd9));
        check("t6_fill_line", 128'(line2), 128'({32'h0000_1234, 32'h0000_1230}));

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
